// File: rtl/fmc_cfg_if.sv
// Configuration handshake bundle for fmc_div_sel_ctrl: requested M/N plus valid/ready.
// A transfer happens on a clk_out edge where cfg_valid and cfg_ready are both high.
interface fmc_cfg_if #(
  parameter int M_W = 2,
  parameter int N_W = 4
);
  logic           cfg_valid;
  logic           cfg_ready;
  logic [M_W-1:0] M;
  logic [N_W-1:0] N;

  modport master (output cfg_valid, M, N, input cfg_ready);
  modport slave  (input cfg_valid, M, N, output cfg_ready);
endinterface

// File: rtl/fmc_div_sel_ctrl.sv
// FMDLL divider / phase-select controller: divides clk_out by N, steps Sel modulo M, frame-aligned reconfig.
// Optional macro FMC_LOCK_DET_EN: lock waits LOCK_FRAMES frames after each apply.
module fmc_div_sel_ctrl #(
  parameter int N_W         = 4,
  parameter int M_W         = 2,
  parameter int SEL_W       = 2,
  parameter int N_RST       = 4,
  parameter int M_RST       = 1,
  parameter int LOCK_FRAMES = 4
) (
  input  logic             clk_out,
  input  logic             rst_n,
  fmc_cfg_if.slave         cfg,
  output logic [N_W-1:0]   N_counter,
  output logic [M_W-1:0]   M_counter,
  output logic             DIV_N,
  output logic [SEL_W-1:0] Sel,
  output logic             frame_start,
  output logic             cfg_err,
  output logic             lock,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } state_t;

  // Largest M that both the Sel range and the M_W-bit register can hold.
  localparam int M_LIM_SEL = 1 << SEL_W;
  localparam int M_LIM_REG = (1 << M_W) - 1;
  localparam int M_MAX     = (M_LIM_SEL < M_LIM_REG) ? M_LIM_SEL : M_LIM_REG;

  if ((N_RST < 1) || (N_RST >= (1 << N_W)) || (M_RST < 1) || (M_RST > M_MAX) ||
      (LOCK_FRAMES < 1)) begin : g_bad_params
    $error("fmc_div_sel_ctrl: reset configuration or LOCK_FRAMES out of range");
  end

  state_t         state_q, state_d;
  logic [N_W-1:0] N_q, N_sh;
  logic [M_W-1:0] M_q, M_sh;
  logic           n_wrap, m_wrap, frame_end;
  logic           cfg_legal, capture, load, err_d;
  logic [N_W:0]   high_len;

  assign n_wrap    = (N_counter == N_q - N_W'(1));
  assign m_wrap    = (M_counter == M_q - M_W'(1));
  assign frame_end = n_wrap && m_wrap;
  assign cfg_legal = (cfg.N != '0) && (cfg.M != '0) && (int'(cfg.M) <= M_MAX);
  assign err_d     = (state_q == RUN) && cfg.cfg_valid && !cfg_legal;
  assign fsm_state = state_q;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    load          = 1'b0;
    cfg.cfg_ready = 1'b0;
    case (state_q)
      RUN: begin
        cfg.cfg_ready = 1'b1;
        if (cfg.cfg_valid && cfg_legal) begin
          capture = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (frame_end) begin
          load    = 1'b1;
          state_d = APPLY;
        end
      end
      APPLY:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // The new ratio loads on the frame-end edge, where both counters wrap to 0 anyway,
  // so APPLY is the first cycle of the new frame and no period is cut short.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      N_q         <= N_W'(N_RST);
      M_q         <= M_W'(M_RST);
      N_sh        <= N_W'(N_RST);
      M_sh        <= M_W'(M_RST);
      N_counter   <= '0;
      M_counter   <= '0;
      frame_start <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      N_counter   <= n_wrap ? '0 : N_counter + N_W'(1);
      if (n_wrap) M_counter <= m_wrap ? '0 : M_counter + M_W'(1);
      frame_start <= frame_end;
      cfg_err     <= err_d;
      if (capture) begin
        N_sh <= cfg.N;
        M_sh <= cfg.M;
      end
      if (load) begin
        N_q <= N_sh;
        M_q <= M_sh;
      end
    end
  end

  // High phase is ceil(N/2) cycles; widened by one bit so N_q = 2^N_W-1 cannot overflow.
  assign high_len = ({1'b0, N_q} + (N_W + 1)'(1)) >> 1;
  assign DIV_N    = ({1'b0, N_counter} < high_len);

  if (SEL_W > M_W) begin : g_sel_ext
    assign Sel = {{(SEL_W - M_W){1'b0}}, M_counter};
  end else if (SEL_W == M_W) begin : g_sel_eq
    assign Sel = M_counter;
  end else begin : g_sel_trunc
    assign Sel = M_counter[SEL_W-1:0];
  end

`ifdef FMC_LOCK_DET_EN
  localparam int FC_W = $clog2(LOCK_FRAMES + 1);
  logic [FC_W-1:0] frame_cnt;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n)                                            frame_cnt <= '0;
    else if (state_q == APPLY)                             frame_cnt <= '0;
    else if (frame_start && (frame_cnt != FC_W'(LOCK_FRAMES))) frame_cnt <= frame_cnt + FC_W'(1);
  end

  assign lock = (state_q == RUN) && (frame_cnt == FC_W'(LOCK_FRAMES));
`else
  logic rst_done;

  // Holds lock low for the first cycle out of reset.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  assign lock = (state_q == RUN) && rst_done;
`endif

endmodule

// File: tb/tb_fmc_div_sel_ctrl.sv
// Directed bench for fmc_div_sel_ctrl: a driver pushes per-cycle expected outputs, a monitor pops and compares.
module tb_fmc_div_sel_ctrl;

  logic       clk_out;
  logic       rst_n;
  logic [3:0] N_counter;
  logic [1:0] M_counter;
  logic       DIV_N;
  logic [1:0] Sel;
  logic       frame_start;
  logic       cfg_err;
  logic       lock;
  logic [1:0] fsm_state;

  fmc_cfg_if #(.M_W(2), .N_W(4)) cfg_bus ();

  fmc_div_sel_ctrl #(
    .N_W(4), .M_W(2), .SEL_W(2), .N_RST(4), .M_RST(1), .LOCK_FRAMES(4)
  ) dut (
    .clk_out    (clk_out),
    .rst_n      (rst_n),
    .cfg        (cfg_bus),
    .N_counter  (N_counter),
    .M_counter  (M_counter),
    .DIV_N      (DIV_N),
    .Sel        (Sel),
    .frame_start(frame_start),
    .cfg_err    (cfg_err),
    .lock       (lock),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  // word layout: div, sel[2], frame_start, ready, err, lock, n_cnt[4], m_cnt[2]
  logic [12:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;

  function automatic logic [12:0] pack(logic div, logic [1:0] sel, logic fs, logic rdy,
                                       logic err, logic lk, logic [3:0] nc, logic [1:0] mc);
    return {div, sel, fs, rdy, err, lk, nc, mc};
  endfunction

  // expected-behaviour model of the active config, counters and handshake state
  int m_N, m_M, m_n, m_m, m_st, sh_N, sh_M;
  bit m_fs, m_err, m_first;

  task automatic model_reset();
    m_N = 4; m_M = 1; m_n = 0; m_m = 0; m_st = 0;
    sh_N = 4; sh_M = 1;
    m_fs = 0; m_err = 0; m_first = 1;
  endtask

  function automatic logic [12:0] model_word();
    logic div;
    div = (m_n < (m_N + 1) / 2);
    return pack(div, 2'(m_m), m_fs, (m_st == 0), m_err, (m_st == 0) && !m_first,
                4'(m_n), 2'(m_m));
  endfunction

  task automatic model_step(bit v, int mm, int nn);
    bit fe, legal, nwrap;
    fe    = (m_n == m_N - 1) && (m_m == m_M - 1);
    nwrap = (m_n == m_N - 1);
    legal = (nn != 0) && (mm != 0) && (mm <= 3);
    m_err = (m_st == 0) && v && !legal;
    m_fs  = fe;
    m_first = 0;
    if (nwrap) m_m = (m_m == m_M - 1) ? 0 : m_m + 1;
    m_n = nwrap ? 0 : m_n + 1;
    case (m_st)
      0: if (v && legal) begin sh_N = nn; sh_M = mm; m_st = 1; end
      1: if (fe) begin m_N = sh_N; m_M = sh_M; m_st = 2; end
      default: m_st = 0;
    endcase
  endtask

  // driver: one call per clock; outputs of this cycle are predicted, then inputs advance the model
  task automatic cycle(bit v, int mm, int nn, bit rst);
    @(posedge clk_out);
    #1;
    cyc++;
    rst_n = !rst;
    if (rst) model_reset();
    cfg_bus.cfg_valid = v;
    cfg_bus.M = 2'(mm);
    cfg_bus.N = 4'(nn);
    exp_q.push_back(model_word());
    if (!rst) model_step(v, mm, nn);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  // monitor / scoreboard
  always @(negedge clk_out) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e, g;
      e = exp_q.pop_front();
      g = pack(DIV_N, Sel, frame_start, cfg_bus.cfg_ready, cfg_err, lock, N_counter, M_counter);
      n_checks++;
      if (g === e) n_pass++;
      else $display("FAIL outputs cyc=%0d got div=%b sel=%0d fs=%b rdy=%b err=%b lock=%b n=%0d m=%0d exp div=%b sel=%0d fs=%b rdy=%b err=%b lock=%b n=%0d m=%0d",
                    cyc, g[12], g[11:10], g[9], g[8], g[7], g[6], g[5:2], g[1:0],
                    e[12], e[11:10], e[9], e[8], e[7], e[6], e[5:2], e[1:0]);
    end
  end

  initial begin
    rst_n = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.M = '0;
    cfg_bus.N = '0;
    model_reset();

    // reset state, then default N=4 M=1
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    idle(13);

    // N=5 M=3 offered mid-frame, applies at the next frame end
    cycle(1, 3, 5, 0);
    idle(45);

    // illegal offers: N=0, then M=0
    cycle(1, 1, 0, 0);
    idle(2);
    cycle(1, 0, 2, 0);
    idle(3);

    // hold valid through PEND with a different N; only N=3 M=2 applies
    cycle(1, 2, 3, 0);
    cycle(1, 2, 6, 0);
    cycle(1, 2, 6, 0);
    idle(30);

    // reset while PEND: pending N=7 never applies
    cycle(1, 2, 7, 0);
    idle(2);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    idle(12);

    // N=1: DIV_N stays high; then capture on a frame-end cycle waits one more frame
    cycle(1, 1, 1, 0);
    idle(12);
    cycle(1, 2, 2, 0);
    idle(14);

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_out);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    if (n_checks < 12) begin
      n_checks++;
      $display("FAIL check_count got=%0d exp>=12", n_checks - 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
